// File: rtl/m_axil_mcl_adapter.sv
// Bridges a single-outstanding MCL request/response packet stream onto an
// AXI-lite master port (32-bit address and data).

`ifndef BSG_AXIL_MOSI_BUS_WIDTH
`define BSG_AXIL_MOSI_BUS_WIDTH(mc_num) ((mc_num)*(32+3+1+32+4+1+1+32+3+1+1))
`endif
`ifndef BSG_AXIL_MISO_BUS_WIDTH
`define BSG_AXIL_MISO_BUS_WIDTH(mc_num) ((mc_num)*(1+1+2+1+1+32+2+1))
`endif

module m_axil_mcl_adapter #(
  parameter int mcl_width_p            = 80,
  parameter int axil_mosi_bus_width_lp = `BSG_AXIL_MOSI_BUS_WIDTH(1),
  parameter int axil_miso_bus_width_lp = `BSG_AXIL_MISO_BUS_WIDTH(1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic [axil_mosi_bus_width_lp-1:0] m_axil_mcl_bus_o,
  input  logic [axil_miso_bus_width_lp-1:0] m_axil_mcl_bus_i,
  input  logic                              mcl_v_i,
  input  logic [mcl_width_p-1:0]            mcl_data_i,
  output logic                              mcl_r_o,
  output logic                              mcl_v_o,
  output logic [mcl_width_p-1:0]            mcl_data_o,
  input  logic                              mcl_r_i
);

  localparam int TagW = mcl_width_p - 72;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRITE_RESP, S_READ, S_READ_RESP, S_SEND
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        op_q, op_d, resp_q, resp_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  assign {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid} = m_axil_mcl_bus_i;

  logic unused_rsvd;
  assign unused_rsvd = ^mcl_data_i[71:70];

  logic awv, wv, accept;
  assign awv    = (state_q == S_WRITE) && !aw_done_q;
  assign wv     = (state_q == S_WRITE) && !w_done_q;
  assign accept = mcl_v_i && mcl_r_o;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    op_d      = op_q;
    tag_d     = tag_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (accept) begin
        wdata_d   = mcl_data_i[31:0];
        addr_d    = mcl_data_i[63:32];
        op_d      = mcl_data_i[65:64];
        wstrb_d   = mcl_data_i[69:66];
        tag_d     = mcl_data_i[mcl_width_p-1:72];
        resp_d    = 2'b00;
        rdata_d   = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        case (mcl_data_i[65:64])
          2'b10:   state_d = S_WRITE;
          2'b01:   state_d = S_READ;
          default: begin
            state_d = S_SEND;
            resp_d  = 2'b10;
          end
        endcase
      end
      // AW and W complete independently; leave once both have been seen.
      S_WRITE: begin
        aw_done_d = aw_done_q || (awv && awready);
        w_done_d  = w_done_q || (wv && wready);
        if (aw_done_d && w_done_d) state_d = S_WRITE_RESP;
      end
      S_WRITE_RESP: if (bvalid) begin
        resp_d  = bresp;
        state_d = S_SEND;
      end
      S_READ: if (arready) state_d = S_READ_RESP;
      S_READ_RESP: if (rvalid) begin
        rdata_d = rdata;
        resp_d  = rresp;
        state_d = S_SEND;
      end
      S_SEND: if (mcl_r_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Reset masks handshake outputs immediately rather than waiting a cycle.
  logic awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  assign awvalid_o = awv && !reset_i;
  assign wvalid_o  = wv && !reset_i;
  assign bready_o  = (state_q == S_WRITE_RESP) && !reset_i;
  assign arvalid_o = (state_q == S_READ) && !reset_i;
  assign rready_o  = (state_q == S_READ_RESP) && !reset_i;

  assign m_axil_mcl_bus_o = {addr_q, 3'b000, awvalid_o, wdata_q, wstrb_q, wvalid_o, bready_o,
                             addr_q, 3'b000, arvalid_o, rready_o};

  assign mcl_r_o    = (state_q == S_IDLE) && !reset_i;
  assign mcl_v_o    = (state_q == S_SEND) && !reset_i;
  assign mcl_data_o = reset_i ? '0 : {tag_q, 36'b0, op_q, resp_q, rdata_q};

endmodule

// File: tb/tb_m_axil_mcl_adapter.sv
// Directed bench for m_axil_mcl_adapter: bench drives the AXI-lite slave side by hand.
module tb_m_axil_mcl_adapter;

  logic clk = 1'b0;
  logic reset_i;
  logic [110:0] mosi;
  logic [40:0]  miso;
  logic mcl_v_i, mcl_r_o, mcl_v_o, mcl_r_i;
  logic [79:0] mcl_data_i, mcl_data_o;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  assign miso = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid};

  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  assign {awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
          araddr, arprot, arvalid, rready} = mosi;

  m_axil_mcl_adapter dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_axil_mcl_bus_o(mosi), .m_axil_mcl_bus_i(miso),
    .mcl_v_i(mcl_v_i), .mcl_data_i(mcl_data_i), .mcl_r_o(mcl_r_o),
    .mcl_v_o(mcl_v_o), .mcl_data_o(mcl_data_o), .mcl_r_i(mcl_r_i)
  );

  always #5 clk = ~clk;

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  always @(posedge clk) if (!reset_i) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt  <= w_cnt + 1;
    if (bvalid && bready)   b_cnt  <= b_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (rvalid && rready)   r_cnt  <= r_cnt + 1;
  end

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pkt(input logic [7:0] tag, input logic [1:0] op,
                                      input logic [3:0] strb, input logic [31:0] addr,
                                      input logic [31:0] dat);
    return {tag, 2'b00, strb, op, addr, dat};
  endfunction

  function automatic logic [79:0] rsp(input logic [7:0] tag, input logic [1:0] op,
                                      input logic [1:0] resp, input logic [31:0] dat);
    return {tag, 36'b0, op, resp, dat};
  endfunction

  initial begin
    reset_i = 1'b1; mcl_v_i = 1'b0; mcl_r_i = 1'b0; mcl_data_i = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0;
    step; step;
    chk("rst_bus", mosi, 0);
    chk("rst_r_o", mcl_r_o, 0);
    chk("rst_v_o", mcl_v_o, 0);
    chk("rst_data", mcl_data_o, 0);
    reset_i = 1'b0;
    step;
    chk("post_rst_r_o", mcl_r_o, 1);

    // Write, slave always ready
    awready = 1; wready = 1;
    mcl_v_i = 1; mcl_data_i = pkt(8'h2A, 2'b10, 4'hF, 32'h1000, 32'hDEADBEEF);
    step; mcl_v_i = 0;
    chk("w1_awvalid", awvalid, 1);
    chk("w1_wvalid", wvalid, 1);
    chk("w1_awaddr", awaddr, 32'h1000);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", wstrb, 4'hF);
    chk("w1_awprot", awprot, 0);
    chk("w1_bready_c1", bready, 0);
    chk("w1_r_o_busy", mcl_r_o, 0);
    bvalid = 1; bresp = 2'b00;
    step;
    chk("w1_bready_c2", bready, 1);
    chk("w1_awvalid_c2", awvalid, 0);
    chk("w1_wvalid_c2", wvalid, 0);
    chk("w1_v_o_c2", mcl_v_o, 0);
    step; bvalid = 0;
    chk("w1_v_o_c3", mcl_v_o, 1);
    chk("w1_rsp", mcl_data_o, rsp(8'h2A, 2'b10, 2'b00, 0));
    mcl_r_i = 1; step; mcl_r_i = 0;
    chk("w1_v_o_done", mcl_v_o, 0);
    chk("w1_r_o_done", mcl_r_o, 1);
    chk("w1_aw_cnt", aw_cnt, 1);
    chk("w1_w_cnt", w_cnt, 1);
    chk("w1_b_cnt", b_cnt, 1);

    // Read with arready delayed 4 cycles
    awready = 0; wready = 0; arready = 0;
    mcl_v_i = 1; mcl_data_i = pkt(8'h11, 2'b01, 4'h0, 32'h10, 32'h0);
    step; mcl_v_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("r1_arvalid_hold", arvalid, 1);
      chk("r1_araddr_hold", araddr, 32'h10);
      step;
    end
    chk("r1_arvalid_5", arvalid, 1);
    chk("r1_arprot", arprot, 0);
    arready = 1;
    step; arready = 0;
    chk("r1_arvalid_off", arvalid, 0);
    chk("r1_rready", rready, 1);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    step; rvalid = 0;
    chk("r1_v_o", mcl_v_o, 1);
    chk("r1_rsp", mcl_data_o, rsp(8'h11, 2'b01, 2'b00, 32'h12345678));
    mcl_r_i = 1; step; mcl_r_i = 0;
    chk("r1_ar_cnt", ar_cnt, 1);
    chk("r1_r_cnt", r_cnt, 1);

    // Write: W handshakes at cycle 1, AW at cycle 4
    awready = 0; wready = 1;
    mcl_v_i = 1; mcl_data_i = pkt(8'h33, 2'b10, 4'h3, 32'h2000, 32'hAABBCCDD);
    step; mcl_v_i = 0;
    chk("w2_both_valid", {awvalid, wvalid}, 2'b11);
    step; wready = 0;
    chk("w2_c2_valids", {awvalid, wvalid}, 2'b10);
    chk("w2_c2_bready", bready, 0);
    step;
    chk("w2_c3_valids", {awvalid, wvalid}, 2'b10);
    chk("w2_c3_bready", bready, 0);
    step;
    chk("w2_c4_awvalid", awvalid, 1);
    chk("w2_c4_bready", bready, 0);
    awready = 1;
    step; awready = 0;
    chk("w2_c5_awvalid", awvalid, 0);
    chk("w2_c5_bready", bready, 1);
    bvalid = 1; bresp = 2'b01;
    step; bvalid = 0;
    chk("w2_rsp", mcl_data_o, rsp(8'h33, 2'b10, 2'b01, 0));
    mcl_r_i = 1; step; mcl_r_i = 0;
    chk("w2_aw_cnt", aw_cnt, 2);
    chk("w2_w_cnt", w_cnt, 2);

    // Write: AW and W handshake in the same (delayed) cycle
    awready = 0; wready = 0;
    mcl_v_i = 1; mcl_data_i = pkt(8'h44, 2'b10, 4'hF, 32'h3000, 32'h11112222);
    step; mcl_v_i = 0;
    chk("w3_c1_valids", {awvalid, wvalid}, 2'b11);
    step;
    chk("w3_c2_valids", {awvalid, wvalid}, 2'b11);
    chk("w3_c2_bready", bready, 0);
    awready = 1; wready = 1;
    step; awready = 0; wready = 0;
    chk("w3_c3_bready", bready, 1);
    chk("w3_c3_valids", {awvalid, wvalid}, 2'b00);
    bvalid = 1; bresp = 2'b00;
    step; bvalid = 0;
    chk("w3_rsp", mcl_data_o, rsp(8'h44, 2'b10, 2'b00, 0));
    mcl_r_i = 1; step; mcl_r_i = 0;
    chk("w3_aw_cnt", aw_cnt, 3);
    chk("w3_w_cnt", w_cnt, 3);

    // Illegal op
    mcl_v_i = 1; mcl_data_i = pkt(8'h07, 2'b11, 4'h0, 32'h0, 32'h0);
    step; mcl_v_i = 0;
    chk("ill_v_o_c1", mcl_v_o, 1);
    chk("ill_rsp", mcl_data_o, rsp(8'h07, 2'b11, 2'b10, 0));
    chk("ill_no_axi", {awvalid, wvalid, arvalid}, 3'b000);
    mcl_r_i = 1; step; mcl_r_i = 0;
    chk("ill_aw_cnt", aw_cnt, 3);
    chk("ill_ar_cnt", ar_cnt, 1);
    chk("ill_r_o", mcl_r_o, 1);

    // Read, then response held off 10 cycles with a second request waiting
    arready = 1; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 2'b00;
    mcl_v_i = 1; mcl_data_i = pkt(8'h55, 2'b01, 4'h0, 32'h40, 32'h0);
    step; mcl_data_i = pkt(8'h66, 2'b01, 4'h0, 32'h20, 32'h0);
    chk("bp_arvalid", arvalid, 1);
    chk("bp_stray_rready", rready, 0);
    step;
    chk("bp_rready", rready, 1);
    step;
    for (int i = 0; i < 10; i++) begin
      chk("bp_v_o_hold", mcl_v_o, 1);
      chk("bp_data_hold", mcl_data_o, rsp(8'h55, 2'b01, 2'b00, 32'hCAFEF00D));
      chk("bp_r_o_hold", mcl_r_o, 0);
      step;
    end
    mcl_r_i = 1;
    step; mcl_r_i = 0;
    chk("bp_idle_r_o", mcl_r_o, 1);
    chk("bp_idle_v_o", mcl_v_o, 0);
    step; mcl_v_i = 0;
    chk("bp2_arvalid", arvalid, 1);
    chk("bp2_araddr", araddr, 32'h20);
    step; step;
    chk("bp2_rsp", mcl_data_o, rsp(8'h66, 2'b01, 2'b00, 32'hCAFEF00D));
    mcl_r_i = 1; step; mcl_r_i = 0;
    arready = 0; rvalid = 0;
    chk("bp_ar_cnt", ar_cnt, 3);
    chk("bp_r_cnt", r_cnt, 3);

    // Reset pulse during WRITE_RESP
    awready = 1; wready = 1;
    mcl_v_i = 1; mcl_data_i = pkt(8'h77, 2'b10, 4'hF, 32'h5000, 32'h1);
    step; mcl_v_i = 0;
    step;
    chk("rp_bready", bready, 1);
    reset_i = 1;
    step;
    chk("rp_bus", mosi, 0);
    chk("rp_v_o", mcl_v_o, 0);
    chk("rp_r_o", mcl_r_o, 0);
    chk("rp_data", mcl_data_o, 0);
    reset_i = 0;
    step;
    chk("rp_r_o_after", mcl_r_o, 1);
    chk("rp_bus_after", mosi, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
